// File: rtl/ca_rule_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : ca_rule_sequencer
// Description : Sequences Wolfram rule codes for a cellular-automaton
//               datapath. Software writes a shadow register bank through a
//               valid/ready port. The bank is copied to the active set at
//               each frame_start. While running, the block steps through
//               up to four rule slots every phase_len generation rows, and
//               it can command a seed-row reload at frame boundaries.
// Revision    : 1.0 - initial release
// ============================================================================
module ca_rule_sequencer #(
    parameter int ROW_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_start,
    input  logic             row_tick,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [2:0]       cfg_addr,
    input  logic [7:0]       cfg_data,
    output logic [7:0]       rule,
    output logic [1:0]       slot,
    output logic             seed,
    output logic             running
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [7:0]       c_RULE0_RST = 8'd30;
    localparam logic [7:0]       c_RULE1_RST = 8'd110;
    localparam logic [7:0]       c_RULE2_RST = 8'd90;
    localparam logic [7:0]       c_RULE3_RST = 8'd184;
    localparam logic [2:0]       c_ADDR_PHASE = 3'd4;
    localparam logic [2:0]       c_ADDR_CTRL  = 3'd5;
    localparam logic [ROW_W-1:0] c_ROW_ONE    = ROW_W'(1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // Register declarations
    // ------------------------------------------------------------------------
    // Shadow bank (software visible)
    logic [3:0][7:0]  sh_rule_q,  sh_rule_d;
    logic [ROW_W-1:0] sh_phase_q, sh_phase_d;
    logic             sh_en_q,    sh_en_d;
    logic [1:0]       sh_nsm1_q,  sh_nsm1_d;

    // Active bank (used by the sequencer)
    logic [3:0][7:0]  act_rule_q,  act_rule_d;
    logic [ROW_W-1:0] act_phase_q, act_phase_d;
    logic [1:0]       act_nsm1_q,  act_nsm1_d;

    // Sequencer state
    state_t           state_q,   state_d;
    logic [ROW_W-1:0] row_cnt_q, row_cnt_d;
    logic [1:0]       slot_q,    slot_d;
    logic             pend_q,    pend_d;
    logic             seed_q,    seed_d;
    logic [7:0]       rule_q,    rule_d;

    logic             w_cfg_xfer;
    logic             w_reseed_wr;

    // The shadow-to-active copy happens in the frame_start cycle, so writes
    // are held off then; this also keeps a reseed write from colliding with
    // the pending-flag clear.
    assign cfg_ready   = ~frame_start;
    assign w_cfg_xfer  = cfg_valid & ~frame_start;
    assign w_reseed_wr = w_cfg_xfer & (cfg_addr == c_ADDR_CTRL) & cfg_data[1];

    // Shadow bank next-state: written only by an accepted config transfer
    always_comb begin
        sh_rule_d  = sh_rule_q;
        sh_phase_d = sh_phase_q;
        sh_en_d    = sh_en_q;
        sh_nsm1_d  = sh_nsm1_q;
        if (w_cfg_xfer) begin
            case (cfg_addr)
                3'd0, 3'd1, 3'd2, 3'd3: begin
                    sh_rule_d[cfg_addr[1:0]] = cfg_data;
                end
                c_ADDR_PHASE: begin
                    sh_phase_d = ROW_W'(cfg_data);
                end
                c_ADDR_CTRL: begin
                    sh_en_d   = cfg_data[0];
                    sh_nsm1_d = cfg_data[3:2];
                end
                default: begin
                    // Addresses 6-7 are accepted and discarded.
                end
            endcase
        end
    end

    // Active bank next-state: copied from shadows only at frame_start
    always_comb begin
        act_rule_d  = act_rule_q;
        act_phase_d = act_phase_q;
        act_nsm1_d  = act_nsm1_q;
        if (frame_start) begin
            act_rule_d  = sh_rule_q;
            act_phase_d = sh_phase_q;
            act_nsm1_d  = sh_nsm1_q;
        end
    end

    // Sequencer FSM next-state, row/slot stepping, seed and rule outputs
    always_comb begin
        state_d   = state_q;
        row_cnt_d = row_cnt_q;
        slot_d    = slot_q;
        seed_d    = 1'b0;
        pend_d    = pend_q | w_reseed_wr;

        case (state_q)
            S_IDLE: begin
                row_cnt_d = '0;
                slot_d    = 2'd0;
                if (frame_start && sh_en_q) begin
                    // Entering RUN always starts from a fresh seed row.
                    state_d = S_RUN;
                    seed_d  = 1'b1;
                    pend_d  = 1'b0;
                end
            end
            S_RUN: begin
                if (frame_start) begin
                    // Frame boundary wins over a coincident row_tick.
                    row_cnt_d = '0;
                    slot_d    = 2'd0;
                    if (!sh_en_q) begin
                        state_d = S_IDLE;
                    end else if (pend_q) begin
                        seed_d = 1'b1;
                        pend_d = 1'b0;
                    end
                end else if (row_tick && (act_phase_q != '0)) begin
                    if (row_cnt_q == (act_phase_q - c_ROW_ONE)) begin
                        row_cnt_d = '0;
                        // >= rather than == so an out-of-range slot can
                        // never walk past the configured slot count.
                        if (slot_q >= act_nsm1_q) begin
                            slot_d = 2'd0;
                        end else begin
                            slot_d = slot_q + 2'd1;
                        end
                    end else begin
                        row_cnt_d = row_cnt_q + c_ROW_ONE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Rule is registered from the next-cycle slot and active bank so that
        // it always agrees with the slot output it is presented alongside.
        if (state_d == S_RUN) begin
            rule_d = act_rule_d[slot_d];
        end else begin
            rule_d = 8'd0;
        end
    end

    // Configuration and active register banks
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_rule_q   <= {c_RULE3_RST, c_RULE2_RST, c_RULE1_RST, c_RULE0_RST};
            sh_phase_q  <= '0;
            sh_en_q     <= 1'b0;
            sh_nsm1_q   <= 2'd0;
            act_rule_q  <= {c_RULE3_RST, c_RULE2_RST, c_RULE1_RST, c_RULE0_RST};
            act_phase_q <= '0;
            act_nsm1_q  <= 2'd0;
        end else begin
            sh_rule_q   <= sh_rule_d;
            sh_phase_q  <= sh_phase_d;
            sh_en_q     <= sh_en_d;
            sh_nsm1_q   <= sh_nsm1_d;
            act_rule_q  <= act_rule_d;
            act_phase_q <= act_phase_d;
            act_nsm1_q  <= act_nsm1_d;
        end
    end

    // Sequencer state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            row_cnt_q <= '0;
            slot_q    <= 2'd0;
            pend_q    <= 1'b0;
            seed_q    <= 1'b0;
            rule_q    <= 8'd0;
        end else begin
            state_q   <= state_d;
            row_cnt_q <= row_cnt_d;
            slot_q    <= slot_d;
            pend_q    <= pend_d;
            seed_q    <= seed_d;
            rule_q    <= rule_d;
        end
    end

    assign rule    = rule_q;
    assign slot    = slot_q;
    assign seed    = seed_q;
    assign running = (state_q == S_RUN);

endmodule
`default_nettype wire

// File: tb/tb_ca_rule_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ca_rule_sequencer
// Description : Directed self-checking bench for ca_rule_sequencer. Each step
//               pushes the expected post-edge outputs to a scoreboard queue;
//               the entry is popped and compared after the clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ca_rule_sequencer;

    logic       clk;
    logic       rst_n;
    logic       frame_start;
    logic       row_tick;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [2:0] cfg_addr;
    logic [7:0] cfg_data;
    logic [7:0] rule;
    logic [1:0] slot;
    logic       seed;
    logic       running;

    typedef struct {
        logic [7:0] rule;
        logic [1:0] slot;
        logic       seed;
        logic       run;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Expected steady-state outputs, used for steps that should not move them
    logic [7:0] e_rule;
    logic [1:0] e_slot;
    logic       e_run;

    ca_rule_sequencer #(.ROW_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .row_tick    (row_tick),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_addr    (cfg_addr),
        .cfg_data    (cfg_data),
        .rule        (rule),
        .slot        (slot),
        .seed        (seed),
        .running     (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Run-time bound
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [7:0] r, input logic [1:0] s,
                                input logic sd, input logic rn);
        exp_t e;
        e.rule = r;
        e.slot = s;
        e.seed = sd;
        e.run  = rn;
        return e;
    endfunction

    // One clock step: drive at negedge, push expectation, compare after edge
    task automatic step(input string tag, input logic fs, input logic rt,
                        input logic v, input logic [2:0] a, input logic [7:0] d,
                        input logic [7:0] x_rule, input logic [1:0] x_slot,
                        input logic x_seed, input logic x_run);
        exp_t got;
        frame_start = fs;
        row_tick    = rt;
        cfg_valid   = v;
        cfg_addr    = a;
        cfg_data    = d;
        sb.push_back(mk(x_rule, x_slot, x_seed, x_run));
        e_rule = x_rule;
        e_slot = x_slot;
        e_run  = x_run;
        #1;
        chk({tag, ".cfg_ready"}, {31'd0, cfg_ready}, {31'd0, ~fs});
        @(posedge clk);
        @(negedge clk);
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s.scoreboard: observed=empty expected=entry", tag);
        end else begin
            got = sb.pop_front();
            chk({tag, ".rule"},    {24'd0, rule},    {24'd0, got.rule});
            chk({tag, ".slot"},    {30'd0, slot},    {30'd0, got.slot});
            chk({tag, ".seed"},    {31'd0, seed},    {31'd0, got.seed});
            chk({tag, ".running"}, {31'd0, running}, {31'd0, got.run});
        end
        frame_start = 1'b0;
        row_tick    = 1'b0;
        cfg_valid   = 1'b0;
    endtask

    // Config write with outputs expected unchanged
    task automatic wr(input string tag, input logic [2:0] a, input logic [7:0] d);
        step(tag, 1'b0, 1'b0, 1'b1, a, d, e_rule, e_slot, 1'b0, e_run);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".rule"},    {24'd0, rule},    32'd0);
        chk({tag, ".slot"},    {30'd0, slot},    32'd0);
        chk({tag, ".seed"},    {31'd0, seed},    32'd0);
        chk({tag, ".running"}, {31'd0, running}, 32'd0);
    endtask

    initial begin
        logic [7:0] exp_rules [8];
        logic [1:0] exp_slots [8];
        exp_rules = '{8'd30, 8'd110, 8'd110, 8'd90, 8'd90, 8'd184, 8'd184, 8'd30};
        exp_slots = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};

        rst_n       = 1'b0;
        frame_start = 1'b0;
        row_tick    = 1'b0;
        cfg_valid   = 1'b0;
        cfg_addr    = 3'd0;
        cfg_data    = 8'd0;
        e_rule      = 8'd0;
        e_slot      = 2'd0;
        e_run       = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk_zero("reset");
        chk("reset.cfg_ready", {31'd0, cfg_ready}, 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // Enable with one slot, first frame seeds
        wr("wr_ctrl01", 3'd5, 8'h01);
        step("fs_enter", 1'b1, 1'b0, 1'b0, 3'd0, 8'd0, 8'd30, 2'd0, 1'b1, 1'b1);
        step("after_enter", 1'b0, 1'b0, 1'b0, 3'd0, 8'd0, 8'd30, 2'd0, 1'b0, 1'b1);

        // Four slots, two rows per phase
        wr("wr_phase2", 3'd4, 8'd2);
        wr("wr_ctrl0d", 3'd5, 8'h0D);
        step("fs_4slot", 1'b1, 1'b0, 1'b0, 3'd0, 8'd0, 8'd30, 2'd0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            step($sformatf("tick%0d", i), 1'b0, 1'b1, 1'b0, 3'd0, 8'd0,
                 exp_rules[i], exp_slots[i], 1'b0, 1'b1);
        end

        // Shadow write does not reach the active rule until frame_start
        wr("wr_slot0", 3'd0, 8'h96);
        step("hold_rule", 1'b0, 1'b0, 1'b0, 3'd0, 8'd0, 8'd30, 2'd0, 1'b0, 1'b1);
        wr("wr_addr6", 3'd6, 8'hFF);
        step("fs_newrule", 1'b1, 1'b0, 1'b0, 3'd0, 8'd0, 8'd150, 2'd0, 1'b0, 1'b1);

        // Coincident frame_start/row_tick with a held config write
        wr("wr_phase1", 3'd4, 8'd1);
        step("tick_cnt1", 1'b0, 1'b1, 1'b0, 3'd0, 8'd0, 8'd150, 2'd0, 1'b0, 1'b1);
        step("fs_rt_coinc", 1'b1, 1'b1, 1'b1, 3'd1, 8'h55, 8'd150, 2'd0, 1'b0, 1'b1);
        step("held_write", 1'b0, 1'b0, 1'b1, 3'd1, 8'h55, 8'd150, 2'd0, 1'b0, 1'b1);
        step("tick_ph1", 1'b0, 1'b1, 1'b0, 3'd0, 8'd0, 8'd110, 2'd1, 1'b0, 1'b1);
        step("fs_slot1new", 1'b1, 1'b0, 1'b0, 3'd0, 8'd0, 8'd150, 2'd0, 1'b0, 1'b1);
        step("tick_slot1", 1'b0, 1'b1, 1'b0, 3'd0, 8'd0, 8'h55, 2'd1, 1'b0, 1'b1);

        // Reseed in RUN: one seed at next frame; slot count shrinks to 1
        wr("wr_ctrl03", 3'd5, 8'h03);
        step("fs_reseed", 1'b1, 1'b0, 1'b0, 3'd0, 8'd0, 8'd150, 2'd0, 1'b1, 1'b1);
        step("seed_1cyc", 1'b0, 1'b0, 1'b0, 3'd0, 8'd0, 8'd150, 2'd0, 1'b0, 1'b1);
        step("tick_1slot", 1'b0, 1'b1, 1'b0, 3'd0, 8'd0, 8'd150, 2'd0, 1'b0, 1'b1);
        step("fs_noseed", 1'b1, 1'b0, 1'b0, 3'd0, 8'd0, 8'd150, 2'd0, 1'b0, 1'b1);
        wr("wr_ctrl00", 3'd5, 8'h00);
        step("fs_to_idle", 1'b1, 1'b0, 1'b0, 3'd0, 8'd0, 8'd0, 2'd0, 1'b0, 1'b0);
        step("idle_tick", 1'b0, 1'b1, 1'b0, 3'd0, 8'd0, 8'd0, 2'd0, 1'b0, 1'b0);

        // Re-enter RUN, advance to slot 2, then asynchronous reset
        wr("wr_ctrl0d_b", 3'd5, 8'h0D);
        step("fs_reenter", 1'b1, 1'b0, 1'b0, 3'd0, 8'd0, 8'd150, 2'd0, 1'b1, 1'b1);
        step("re_tick1", 1'b0, 1'b1, 1'b0, 3'd0, 8'd0, 8'h55, 2'd1, 1'b0, 1'b1);
        step("re_tick2", 1'b0, 1'b1, 1'b0, 3'd0, 8'd0, 8'd90, 2'd2, 1'b0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        e_rule = 8'd0;
        e_slot = 2'd0;
        e_run  = 1'b0;

        // After reset: waits in IDLE, shadows back to defaults
        step("rst_fs_noen", 1'b1, 1'b0, 1'b0, 3'd0, 8'd0, 8'd0, 2'd0, 1'b0, 1'b0);
        wr("rst_wr_ctrl", 3'd5, 8'h0D);
        step("rst_fs_en", 1'b1, 1'b0, 1'b0, 3'd0, 8'd0, 8'd30, 2'd0, 1'b1, 1'b1);
        wr("rst_wr_ph", 3'd4, 8'd1);
        step("rst_fs2", 1'b1, 1'b0, 1'b0, 3'd0, 8'd0, 8'd30, 2'd0, 1'b0, 1'b1);
        step("rst_tick1", 1'b0, 1'b1, 1'b0, 3'd0, 8'd0, 8'd110, 2'd1, 1'b0, 1'b1);
        step("rst_tick2", 1'b0, 1'b1, 1'b0, 3'd0, 8'd0, 8'd90, 2'd2, 1'b0, 1'b1);
        step("rst_tick3", 1'b0, 1'b1, 1'b0, 3'd0, 8'd0, 8'd184, 2'd3, 1'b0, 1'b1);

        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: observed=%0d expected=0", sb.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ca_rule_sequencer.md
CA_RULE_SEQUENCER -- requirements
Module: ca_rule_sequencer

Interface
REQ-001 Parameter: ROW_W, default 8, width of the row-phase counter and phase-length register.
REQ-002 Port: clk  in  1  pixel clock; all state changes on rising edge.
REQ-003 Port: rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 Port: frame_start  in  1  one-cycle pulse at first pixel of each frame.
REQ-005 Port: row_tick  in  1  one-cycle pulse at start of each new CA generation row.
REQ-006 Port: cfg_valid  in  1  config write request.
REQ-007 Port: cfg_ready  out  1  config write accept; transfer when cfg_valid & cfg_ready.
REQ-008 Port: cfg_addr  in  3  register select: 0-3 rule slots, 4 phase length, 5 control.
REQ-009 Port: cfg_data  in  8  write data.
REQ-010 Port: rule  out  8  active Wolfram rule code for the CA datapath.
REQ-011 Port: slot  out  2  index of active rule slot.
REQ-012 Port: seed  out  1  one-cycle pulse commanding the datapath to reload the seed row.
REQ-013 Port: running  out  1  high in state RUN.

Function
REQ-014 Shadow registers SHALL be written only on a cfg transfer; active registers SHALL be loaded from shadows only in a frame_start cycle.
REQ-015 cfg_ready SHALL equal ~frame_start (no write accepted in the copy cycle).
REQ-016 Control register: bit0 enable, bit1 reseed (write-1 sets sticky reseed_pending, write-0 no effect), bits3:2 nslots-1; bits7:4 ignored.
REQ-017 Phase-length write SHALL store cfg_data[ROW_W-1:0]; addr 6-7 writes SHALL be accepted and discarded.
REQ-018 FSM states: IDLE, RUN.
REQ-019 IDLE: rule=0, slot=0, running=0, row_tick ignored.
REQ-020 IDLE -> RUN on frame_start with shadow enable=1; same cycle edge: seed pulses for one cycle, reseed_pending cleared.
REQ-021 RUN -> IDLE on frame_start with shadow enable=0; no seed pulse; rule/slot forced to 0 next cycle.
REQ-022 In RUN, every frame_start SHALL reset row_cnt=0 and slot=0; seed SHALL pulse iff reseed_pending, which is then cleared.
REQ-023 In RUN, row_tick without frame_start: if active phase_len=0 no change; else row_cnt increments, and when row_cnt==phase_len-1 row_cnt->0 and slot->(slot==nslots-1 ? 0 : slot+1).
REQ-024 Simultaneous frame_start and row_tick: frame_start action only; row_tick dropped.
REQ-025 Reseed write in the same cycle a seed pulse clears pending SHALL be impossible (cfg_ready low); pending set earlier in a frame SHALL produce seed at the next frame_start.
REQ-026 rule SHALL be registered: rule = active_rule[slot], valid the cycle after any slot or active-register change (latency 1 clock).
REQ-027 seed SHALL be registered, high exactly one cycle, following the frame_start cycle.
REQ-028 If nslots-1 is reduced such that slot exceeds it, slot SHALL be 0 after the frame_start (guaranteed by REQ-022).

Reset
REQ-029 On rst_n low, asynchronously: state=IDLE, rule=0, slot=0, seed=0, running=0, row_cnt=0, reseed_pending=0.
REQ-030 Shadow and active reset values: slots 30,110,90,184; phase_len 0; control 0 (disabled, nslots=1).
REQ-031 rst_n asserted mid-frame SHALL abort RUN; after release the block waits in IDLE for the next frame_start with enable set.

Verification
REQ-032 Reset, write ctrl=0x01, frame_start -> seed pulse 1 cycle, running=1, rule=30, slot=0.
REQ-033 ctrl=0x0D (enable, 4 slots), phase_len=2, frame_start then 8 row_ticks -> slot 0,0,1,1,2,2,3,3 then 0; rule 30,30,110,110,90,90,184,184.
REQ-034 Write slot0=0x96 mid-frame -> rule stays 30 until next frame_start, then 150.
REQ-035 frame_start and row_tick coincident with phase_len=1 -> slot=0, row_cnt=0, cfg_ready=0 that cycle, write held by master accepted next cycle.
REQ-036 ctrl=0x03 write in RUN -> exactly one seed pulse at next frame_start, none at the following one; ctrl=0x00 then frame_start -> IDLE, rule=0.
REQ-037 rst_n low during RUN with slot=2 -> outputs 0 immediately (no clock), slots back to 30,110,90,184.
